// File: rtl/dest_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// dest_hazard_scoreboard_if
// Purpose : groups the ID-stage request and the hazard/forwarding response of
//           dest_hazard_scoreboard into one bundle.
// Signals :
//   ifid_out  [31:0]   ID-stage instruction (rs=[25:21], rt=[20:16], rd=[15:11])
//   regrt              1: destination = rt, 0: destination = rd
//   wreg_id            ID instruction writes the register file
//   m2reg_id           ID instruction is a load
//   uses_rs/uses_rt    ID instruction reads rs / rt
//   flush              discard the ID instruction
//   dest_id   [RA_W]   selected destination of the ID instruction
//   stall              hold PC and IF/ID, bubble into EX
//   fwda/fwdb [1:0]    operand source: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   stall_cnt [CNT_W]  saturating count of stall cycles since reset
//   wb_v/wb_dst/wb_ld  WB slot contents, observability only
// Modports: master drives the request and reads the response; slave is the
//           scoreboard side.
// ----------------------------------------------------------------------------
interface dest_hazard_scoreboard_if #(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      ifid_out;
    logic             regrt;
    logic             wreg_id;
    logic             m2reg_id;
    logic             uses_rs;
    logic             uses_rt;
    logic             flush;
    logic [RA_W-1:0]  dest_id;
    logic             stall;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;
    logic             wb_v;
    logic [RA_W-1:0]  wb_dst;
    logic             wb_ld;

    modport master (
        output ifid_out, regrt, wreg_id, m2reg_id, uses_rs, uses_rt, flush,
        input  dest_id, stall, fwda, fwdb, stall_cnt, wb_v, wb_dst, wb_ld
    );

    modport slave (
        input  ifid_out, regrt, wreg_id, m2reg_id, uses_rs, uses_rt, flush,
        output dest_id, stall, fwda, fwdb, stall_cnt, wb_v, wb_dst, wb_ld
    );
endinterface

// File: rtl/dest_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// dest_hazard_scoreboard
// Purpose : sits beside the ID stage. Selects the destination register of the
//           ID instruction, tracks in-flight register writes through the EX,
//           MEM and WB slots, raises the load-use stall and produces the
//           decode-stage forwarding selects.
// Ports   :
//   clk    pipeline clock, posedge-sampled
//   rst_n  asynchronous active-low reset; clears all slots and the counter
//   hz     dest_hazard_scoreboard_if.slave (request in, hazard response out)
// Field positions in ifid_out fix RA_W at 5.
// ----------------------------------------------------------------------------
module dest_hazard_scoreboard #(
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dest_hazard_scoreboard_if.slave hz
);
    logic [RA_W-1:0]  w_rs;
    logic [RA_W-1:0]  w_rt;
    logic [RA_W-1:0]  w_rd;
    logic [RA_W-1:0]  w_dest;
    logic             w_ex_alloc;
    logic             w_stall;
    logic [1:0]       w_fwda;
    logic [1:0]       w_fwdb;
    logic             w_unused_instr;

    logic             r_ex_v;
    logic [RA_W-1:0]  r_ex_dst;
    logic             r_ex_ld;
    logic             r_mem_v;
    logic [RA_W-1:0]  r_mem_dst;
    logic             r_mem_ld;
    logic             r_wb_v;
    logic [RA_W-1:0]  r_wb_dst;
    logic             r_wb_ld;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_rs   = hz.ifid_out[25:21];
    assign w_rt   = hz.ifid_out[20:16];
    assign w_rd   = hz.ifid_out[15:11];
    assign w_dest = hz.regrt ? w_rt : w_rd;

    // Opcode/funct bits are decoded elsewhere.
    assign w_unused_instr = ^{hz.ifid_out[31:26], hz.ifid_out[10:0]};

    // r0 writes are never tracked, so a valid slot always has dst != 0 and
    // r0 can never match a hazard.
    assign w_ex_alloc = hz.wreg_id & (w_dest != '0) & ~w_stall & ~hz.flush;

    // Load in EX feeding an operand: the data only exists after MEM.
    always_comb begin
        w_stall = 1'b0;
        if (r_ex_v && r_ex_ld && !hz.flush) begin
            w_stall = (hz.uses_rs && (r_ex_dst == w_rs)) ||
                      (hz.uses_rt && (r_ex_dst == w_rt));
        end
    end

    // Youngest producer wins. A load in EX skips to the MEM check; that case
    // stalls, so the select is ignored for that cycle. WB needs no path since
    // the register file writes on negedge and is read after.
    function automatic logic [1:0] fwd_sel(
        input logic            uses,
        input logic [RA_W-1:0] src,
        input logic            ex_v,
        input logic [RA_W-1:0] ex_dst,
        input logic            ex_ld,
        input logic            mem_v,
        input logic [RA_W-1:0] mem_dst,
        input logic            mem_ld
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && (src != '0)) begin
            if (ex_v && !ex_ld && (ex_dst == src)) begin
                sel = 2'b01;
            end else if (mem_v && (mem_dst == src)) begin
                sel = mem_ld ? 2'b11 : 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_fwda = fwd_sel(hz.uses_rs, w_rs, r_ex_v, r_ex_dst, r_ex_ld,
                         r_mem_v, r_mem_dst, r_mem_ld);
        w_fwdb = fwd_sel(hz.uses_rt, w_rt, r_ex_v, r_ex_dst, r_ex_ld,
                         r_mem_v, r_mem_dst, r_mem_ld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v      <= 1'b0;
            r_ex_dst    <= '0;
            r_ex_ld     <= 1'b0;
            r_mem_v     <= 1'b0;
            r_mem_dst   <= '0;
            r_mem_ld    <= 1'b0;
            r_wb_v      <= 1'b0;
            r_wb_dst    <= '0;
            r_wb_ld     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_ex_v    <= w_ex_alloc;
            r_ex_dst  <= w_dest;
            r_ex_ld   <= hz.m2reg_id;
            r_mem_v   <= r_ex_v;
            r_mem_dst <= r_ex_dst;
            r_mem_ld  <= r_ex_ld;
            r_wb_v    <= r_mem_v;
            r_wb_dst  <= r_mem_dst;
            r_wb_ld   <= r_mem_ld;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign hz.dest_id   = w_dest;
    assign hz.stall     = w_stall;
    assign hz.fwda      = w_fwda;
    assign hz.fwdb      = w_fwdb;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.wb_v      = r_wb_v;
    assign hz.wb_dst    = r_wb_dst;
    assign hz.wb_ld     = r_wb_ld;
endmodule

// File: tb/tb_dest_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_dest_hazard_scoreboard
// Drives directed and random ID-stage instructions into two scoreboards (wide
// and 2-bit stall counter) sharing the same stimulus. The driver predicts the
// response from a list of recently issued producers and queues it; a monitor
// on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_dest_hazard_scoreboard;
    logic clk;
    logic rst_n;

    dest_hazard_scoreboard_if #(.RA_W(5), .CNT_W(16)) hz ();
    dest_hazard_scoreboard_if #(.RA_W(5), .CNT_W(2))  hz_s ();

    dest_hazard_scoreboard #(.RA_W(5), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    dest_hazard_scoreboard #(.RA_W(5), .CNT_W(2)) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_s.slave)
    );

    assign hz_s.ifid_out = hz.ifid_out;
    assign hz_s.regrt    = hz.regrt;
    assign hz_s.wreg_id  = hz.wreg_id;
    assign hz_s.m2reg_id = hz.m2reg_id;
    assign hz_s.uses_rs  = hz.uses_rs;
    assign hz_s.uses_rt  = hz.uses_rt;
    assign hz_s.flush    = hz.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An issued instruction that may write a register.
    typedef struct {
        bit       writes;
        bit [4:0] dst;
        bit       is_load;
    } prod_t;

    typedef struct {
        bit [4:0] dest;
        bit       stall;
        bit [1:0] fa;
        bit [1:0] fb;
        bit       fa_dc;
        bit       fb_dc;
        int       cnt;
    } exp_t;

    exp_t  exp_q[$];
    prod_t hist[$];    // hist[1] issued one cycle ago, hist[0] two cycles ago
    int    model_cnt;
    int    n_checks;
    int    n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        prod_t empty;
        empty = '{writes: 1'b0, dst: 5'd0, is_load: 1'b0};
        hist.delete();
        hist.push_back(empty);
        hist.push_back(empty);
        model_cnt = 0;
    endtask

    // Newest producer of src supplies it; a load one cycle old has no data yet.
    function automatic void fwd_model(input bit uses, input bit [4:0] src,
                                      output bit [1:0] code, output bit load_wait);
        code      = 2'b00;
        load_wait = 1'b0;
        if (uses && src != 5'd0) begin
            if (hist[1].writes && hist[1].dst == src) begin
                if (hist[1].is_load) load_wait = 1'b1;
                else                 code = 2'b01;
            end else if (hist[0].writes && hist[0].dst == src) begin
                code = hist[0].is_load ? 2'b11 : 2'b10;
            end
        end
    endfunction

    task automatic issue(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                         input bit regrt, input bit wreg, input bit m2reg,
                         input bit urs, input bit urt, input bit fl);
        exp_t     e;
        prod_t    p;
        bit       wa;
        bit       wb;
        bit [5:0] opc;
        bit [10:0] low;
        @(posedge clk);
        #2;
        opc = 6'($urandom);
        low = 11'($urandom);
        hz.ifid_out = {opc, rs, rt, rd, low};
        hz.regrt    = regrt;
        hz.wreg_id  = wreg;
        hz.m2reg_id = m2reg;
        hz.uses_rs  = urs;
        hz.uses_rt  = urt;
        hz.flush    = fl;

        e.dest = regrt ? rt : rd;
        fwd_model(urs, rs, e.fa, wa);
        fwd_model(urt, rt, e.fb, wb);
        e.fa_dc = wa;
        e.fb_dc = wb;
        e.stall = !fl && (wa || wb);
        e.cnt   = model_cnt;
        exp_q.push_back(e);

        p.writes  = wreg && e.dest != 5'd0 && !e.stall && !fl;
        p.dst     = e.dest;
        p.is_load = m2reg;
        hist.push_back(p);
        void'(hist.pop_front());
        if (e.stall) model_cnt++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   sat;
        if (rst_n && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            sat = (e.cnt > 3) ? 3 : e.cnt;
            check("dest_id", 32'(hz.dest_id), 32'(e.dest));
            check("stall", 32'(hz.stall), 32'(e.stall));
            if (!e.fa_dc) check("fwda", 32'(hz.fwda), 32'(e.fa));
            if (!e.fb_dc) check("fwdb", 32'(hz.fwdb), 32'(e.fb));
            check("stall_cnt", 32'(hz.stall_cnt), 32'(e.cnt));
            check("stall_cnt_sat", 32'(hz_s.stall_cnt), 32'(sat));
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n       = 1'b0;
        hz.ifid_out = 32'd0;
        hz.regrt    = 1'b0;
        hz.wreg_id  = 1'b0;
        hz.m2reg_id = 1'b0;
        hz.uses_rs  = 1'b0;
        hz.uses_rt  = 1'b0;
        hz.flush    = 1'b0;
        #1;
        check("rst_stall", 32'(hz.stall), 32'd0);
        check("rst_fwda", 32'(hz.fwda), 32'd0);
        check("rst_fwdb", 32'(hz.fwdb), 32'd0);
        check("rst_cnt", 32'(hz.stall_cnt), 32'd0);
        #11 rst_n = 1'b1;

        // destination select
        issue(5'd1, 5'd9, 5'd4, 1, 0, 0, 0, 0, 0);
        issue(5'd1, 5'd9, 5'd4, 0, 0, 0, 0, 0, 0);
        // ALU r5 then readers at distance 1 and 2
        issue(5'd0, 5'd0, 5'd5, 0, 1, 0, 0, 0, 0);
        issue(5'd5, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        issue(5'd5, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        // lw r8, then rt reader stalls once and retries
        issue(5'd0, 5'd8, 5'd0, 1, 1, 1, 0, 0, 0);
        issue(5'd0, 5'd8, 5'd7, 0, 0, 0, 0, 1, 0);
        issue(5'd0, 5'd8, 5'd7, 0, 0, 0, 0, 1, 0);
        // writes to r0 are never hazards
        issue(5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0);
        issue(5'd0, 5'd0, 5'd0, 0, 1, 0, 1, 1, 0);
        issue(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0);
        // flushed lw r3 allocates nothing
        issue(5'd0, 5'd3, 5'd0, 1, 1, 1, 0, 0, 1);
        issue(5'd3, 5'd3, 5'd0, 0, 0, 0, 1, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0));
        end

        // Reset while a load-use stall is active.
        issue(5'd0, 5'd8, 5'd0, 1, 1, 1, 0, 0, 0);
        issue(5'd8, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_stall", 32'(hz.stall), 32'd0);
        check("midrst_fwda", 32'(hz.fwda), 32'd0);
        check("midrst_cnt", 32'(hz.stall_cnt), 32'd0);
        check("midrst_cnt_s", 32'(hz_s.stall_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Five load-use stalls: wide counter reads 5, 2-bit counter saturates.
        for (int i = 0; i < 5; i++) begin
            issue(5'd0, 5'd6, 5'd0, 1, 1, 1, 0, 0, 0);
            issue(5'd6, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
            issue(5'd6, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        end
        @(posedge clk);
        #2;
        check("cnt_five", 32'(hz.stall_cnt), 32'd5);
        check("cnt_sat", 32'(hz_s.stall_cnt), 32'd3);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
